scroll_msg_display: RTL

//  Parametrised scrolling-message engine for the seven-segment bank. Holds a writable
//  MSG_LEN-character message (reset content "HELLO" + blanks) and presents a rotating
//  NUM_DIGITS-wide window, advanced by a manual step or by an internal rate divider.

---
 rtl/scroll_msg_display.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/scroll_msg_display.sv
// scroll_msg_display: scrolling-message engine for the seven-segment bank.
// Holds a writable MSG_LEN-character message and presents a rotating
// NUM_DIGITS-wide window, advanced by a manual step edge or an internal
// rate divider. Optional feature macro: SCROLL_BLINK_EN (blink phase flop).
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_MANUAL | advance only on step rising edge; divider held at 0
// S_AUTO   | divider counts 0..rate-1, tick advances; step edges too
module scroll_msg_display #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 8,
  parameter int CHAR_W     = 4,
  parameter int DIV_W      = 24
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic                         step,
  input  logic                         auto_en,
  input  logic                         dir,
  input  logic [DIV_W-1:0]             rate,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_idx,
  input  logic [CHAR_W-1:0]            wr_char,
  input  logic                         blink,
  output logic [NUM_DIGITS*CHAR_W-1:0] digits,
  output logic [$clog2(MSG_LEN)-1:0]   pos,
  output logic                         wrap
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam logic [CHAR_W-1:0] CH_H  = CHAR_W'(0);
  localparam logic [CHAR_W-1:0] CH_E  = CHAR_W'(1);
  localparam logic [CHAR_W-1:0] CH_L  = CHAR_W'(2);
  localparam logic [CHAR_W-1:0] CH_O  = CHAR_W'(3);
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(4);

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt, rate_m1;
  logic              step_q, step_edge, tick, advance;
  logic [IDX_W-1:0]  pos_nxt;
  logic              wrap_nxt;
  logic [CHAR_W-1:0] msg [MSG_LEN];
  logic [NUM_DIGITS*CHAR_W-1:0] window, disp;
  int                win_idx;

  // "HELLO" followed by blanks; indices past MSG_LEN never get asked for
  function automatic logic [CHAR_W-1:0] reset_char(input int k);
    case (k)
      0:       return CH_H;
      1:       return CH_E;
      2:       return CH_L;
      3:       return CH_L;
      4:       return CH_O;
      default: return BLANK;
    endcase
  endfunction

  function automatic logic [NUM_DIGITS*CHAR_W-1:0] reset_window();
    logic [NUM_DIGITS*CHAR_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w[i*CHAR_W +: CHAR_W] = reset_char((NUM_DIGITS - 1 - i) % MSG_LEN);
    return w;
  endfunction

  assign step_edge = step & ~step_q;
  assign rate_m1   = (rate == '0) ? '0 : rate - 1'b1;
  assign advance   = tick | step_edge;

  // Mode transitions and divider; the tick needs auto_en still high so a mode drop loses it
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    tick      = 1'b0;
    case (state)
      S_MANUAL: begin
        div_nxt = '0;
        if (auto_en) state_nxt = S_AUTO;
      end
      S_AUTO: begin
        if (!auto_en) begin
          state_nxt = S_MANUAL;
          div_nxt   = '0;
        end else if (div_cnt >= rate_m1) begin
          tick    = 1'b1;
          div_nxt = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_MANUAL;
        div_nxt   = '0;
      end
    endcase
  end

  // Next window position with wrap detection at either end
  always_comb begin
    pos_nxt  = pos;
    wrap_nxt = 1'b0;
    if (advance) begin
      if (!dir) begin
        if (pos == IDX_W'(MSG_LEN - 1)) begin
          pos_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          pos_nxt  = IDX_W'(MSG_LEN - 1);
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos - 1'b1;
        end
      end
    end
  end

  // Window view of the message; slice NUM_DIGITS-1 (leftmost) shows msg[pos]
  always_comb begin
    window  = '0;
    win_idx = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      win_idx = (int'(pos) + NUM_DIGITS - 1 - i) % MSG_LEN;
      window[i*CHAR_W +: CHAR_W] = msg[win_idx[IDX_W-1:0]];
    end
  end

`ifdef SCROLL_BLINK_EN
  logic phase;

  // Blink phase follows the advance source of the current mode
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      phase <= 1'b0;
    else if (tick || (state == S_MANUAL && step_edge))
      phase <= ~phase;
  end

  assign disp = (blink && phase) ? {NUM_DIGITS{BLANK}} : window;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign disp = window;
`endif

  // Control registers and the registered digit outputs
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= S_MANUAL;
      div_cnt <= '0;
      step_q  <= 1'b0;
      pos     <= '0;
      wrap    <= 1'b0;
      digits  <= reset_window();
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      step_q  <= step;
      pos     <= pos_nxt;
      wrap    <= wrap_nxt;
      digits  <= disp;
    end
  end

  // Message storage; a write lands alongside any advance in the same cycle
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MSG_LEN; k++) msg[k] <= reset_char(k);
    end else if (wr_en && (int'(wr_idx) < MSG_LEN)) begin
      msg[wr_idx] <= wr_char;
    end
  end

endmodule
